apb_rr_master: RTL
==================

// Module: apb_rr_master
// PURPOSE
//   APB requester-side controller that shares one APB slave (e.g. the 32x32 APB
//   memory) between NREQ local requesters. Round-robin arbitration; drives
//   IDLE->SETUP->ACCESS phases, waits on pready, returns read data and error,
//   and aborts a stalled transfer after a timeout.
// PARAMETERS
//   NREQ     2   number of requesters (>=2)
//   AW       32  APB address width
//   DW       32  APB data width
//   TIMEOUT  16  max consecutive ACCESS cycles with pready=0 before abort (>=2)
// PORTS
//   pclk       in   1        clock, rising edge
//   prst       in   1        reset, asynchronous, active-low
//   req        in   NREQ     per-requester transfer request, level, held until done
//   req_write  in   NREQ     per-requester 1=write, 0=read
//   req_addr   in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in   NREQ*DW  packed write data, requester i at [i*DW +: DW]
//   done       out  NREQ     one-cycle completion pulse, one-hot
//   rsp_rdata  out  DW       read data, valid while done!=0
//   rsp_err    out  1        slave error or timeout, valid while done!=0
//   paddr      out  AW       APB address
//   pselx      out  1        APB select
//   penable    out  1        APB enable
//   pwrite     out  1        APB direction
//   pwdata     out  DW       APB write data
//   pready     in   1        APB ready from slave
//   pslverr    in   1        APB error from slave
//   prdata     in   DW       APB read data from slave
// BEHAVIOUR
//   Reset (prst=0, async): state=IDLE; all outputs 0; last_grant=NREQ-1, so
//     requester 0 wins first; timeout counter=0.
//   States and registered outputs:
//     IDLE:   pselx=0, penable=0.
//     SETUP:  pselx=1, penable=0.
//     ACCESS: pselx=1, penable=1.
//   IDLE: if done!=0 this cycle, stay IDLE (requests are not sampled). Otherwise,
//     if any req, grant the first set req searching from last_grant+1 mod NREQ.
//     Latch that requester's addr/write/wdata into paddr/pwrite/pwdata, then go
//     to SETUP. If no req, stay IDLE.
//   SETUP: always go to ACCESS after exactly 1 cycle.
//   ACCESS: paddr/pwrite/pwdata/pselx/penable stay stable.
//     On a pready=1 sample, go to IDLE. Next cycle: done[grant]=1,
//       rsp_err=pslverr, rsp_rdata=prdata for a read (0 for a write),
//       last_grant=grant.
//     On a pready=0 sample, increment the counter. When the counter reaches
//       TIMEOUT, go to IDLE with done[grant]=1, rsp_err=1, rsp_rdata=0.
//   On leaving ACCESS: pselx, penable, paddr, pwrite and pwdata return to 0.
//   Counter clears on entry to SETUP.
//   done, rsp_rdata and rsp_err are 0 in every cycle except the done cycle.
//   Latency: req seen at edge 0 -> SETUP at edge 0, ACCESS at edge 1; if pready=1
//     at edge 2, done is high in the cycle after edge 2. Minimum is 3 cycles from
//     req to done, then 1 forced IDLE cycle, so 4 cycles per back-to-back transfer.
//   Requester drops req during the transfer: ignored; the transfer completes and
//     done still pulses.
//   Requester must deassert req or present a new request in its done cycle.
//   Simultaneous requests: round-robin only; no starvation. With all requesters
//     asserting, each is served once per NREQ transfers.
//   Reset mid-transfer: the bus returns to idle immediately (async); no done pulse.
// TESTING
//   T1 write: req[0], write, addr=0x5, wdata=0xA5A5A5A5, slave pready=1 in ACCESS
//      -> SETUP 1 cycle, ACCESS 1 cycle, paddr=5, pwrite=1,
//      done[0] high 3 cycles after req, rsp_err=0.
//   T2 readback: req[1], read, addr=0x5 -> prdata sampled,
//      rsp_rdata=0xA5A5A5A5 with done[1], pwrite=0 throughout.
//   T3 arbitration: after reset, req=2'b11 held
//      -> grants 0,1,0,1; each done separated by >=4 cycles.
//      Then req=2'b10 only -> grant 1 immediately.
//   T4 wait states: pready=0 for 3 ACCESS cycles, then 1
//      -> penable/paddr stable 4 ACCESS cycles; done 1 cycle after pready; rsp_err=0.
//   T5 timeout/err: pready stuck 0 -> done after exactly 16 ACCESS cycles,
//      rsp_err=1, rsp_rdata=0.
//      Separate run with pslverr=1 at pready -> rsp_err=1.
//   T6 reset mid-ACCESS: drop prst -> pselx=penable=0 asynchronously, done=0;
//      after release the first grant goes to requester 0.

Source files
------------

// File: rtl/apb_rr_master.sv
// -----------------------------------------------------------------------------
// apb_rr_master
//
// Purpose:
//   Requester-side APB controller that shares a single APB slave between NREQ
//   local requesters. A round-robin arbiter picks one pending request, the FSM
//   walks the bus through SETUP and ACCESS, waits on pready, and hands the read
//   data and error status back to the winning requester with a one-cycle,
//   one-hot done pulse. A transfer that stalls in ACCESS for TIMEOUT cycles is
//   aborted and reported as an error.
//
// Ports:
//   pclk_i        clock, rising edge
//   prst_i        asynchronous active-low reset
//   req_i         per-requester request level, held until its done pulse
//   req_write_i   per-requester direction (1 = write, 0 = read)
//   req_addr_i    packed addresses, requester i at [i*AW +: AW]
//   req_wdata_i   packed write data, requester i at [i*DW +: DW]
//   done_o        one-hot completion pulse, one cycle long
//   rsp_rdata_o   read data, valid only while done_o != 0 (0 for writes)
//   rsp_err_o     slave error or timeout, valid only while done_o != 0
//   paddr_o       APB address
//   pselx_o       APB select
//   penable_o     APB enable
//   pwrite_o      APB direction
//   pwdata_o      APB write data
//   pready_i      APB ready from slave
//   pslverr_i     APB error from slave
//   prdata_i      APB read data from slave
// -----------------------------------------------------------------------------
module apb_rr_master #(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                 pclk_i,
    input  logic                 prst_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ-1:0]      req_write_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*DW-1:0]   req_wdata_i,
    output logic [NREQ-1:0]      done_o,
    output logic [DW-1:0]        rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic [AW-1:0]        paddr_o,
    output logic                 pselx_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [DW-1:0]        pwdata_o,
    input  logic                 pready_i,
    input  logic                 pslverr_i,
    input  logic [DW-1:0]        prdata_i
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   paddr_q, paddr_d;
    logic            pwrite_q, pwrite_d;
    logic [DW-1:0]   pwdata_q, pwdata_d;
    logic            pselx_q, penable_q;
    logic [NREQ-1:0] done_q, done_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            found;
    logic [GW-1:0]   pick;

    // Round-robin search: start one past the last served requester and take
    // the first pending request, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_grant_q) + k) % NREQ;
            if (!found && req_i[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    // Next-state and datapath. The IDLE state refuses to sample requests
    // during the done cycle, which forces one idle cycle between transfers
    // and gives the finished requester time to drop its request.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        done_d       = '0;
        rdata_d      = '0;
        err_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((done_q == '0) && found) begin
                    grant_d  = pick;
                    paddr_d  = req_addr_i[int'(pick)*AW +: AW];
                    pwrite_d = req_write_i[pick];
                    pwdata_d = req_wdata_i[int'(pick)*DW +: DW];
                    cnt_d    = '0;
                    state_d  = S_SETUP;
                end
            end

            S_SETUP: begin
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                if (pready_i) begin
                    state_d         = S_IDLE;
                    done_d[grant_q] = 1'b1;
                    err_d           = pslverr_i;
                    rdata_d         = pwrite_q ? '0 : prdata_i;
                    last_grant_d    = grant_q;
                    paddr_d         = '0;
                    pwrite_d        = 1'b0;
                    pwdata_d        = '0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // This stalled cycle is the TIMEOUT-th one: abort.
                    state_d         = S_IDLE;
                    done_d[grant_q] = 1'b1;
                    err_d           = 1'b1;
                    last_grant_d    = grant_q;
                    paddr_d         = '0;
                    pwrite_d        = 1'b0;
                    pwdata_d        = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. last_grant resets to the highest index so
    // that requester 0 wins the first arbitration after reset.
    always_ff @(posedge pclk_i or negedge prst_i) begin
        if (!prst_i) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NREQ - 1);
            cnt_q        <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pselx_q      <= 1'b0;
            penable_q    <= 1'b0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pselx_q      <= (state_d != S_IDLE);
            penable_q    <= (state_d == S_ACCESS);
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    assign done_o      = done_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign paddr_o     = paddr_q;
    assign pselx_o     = pselx_q;
    assign penable_o   = penable_q;
    assign pwrite_o    = pwrite_q;
    assign pwdata_o    = pwdata_q;

endmodule
